// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the 4-way ALU arbiter.
interface alu_arbiter_if;
  logic [3:0]  req_valid;
  logic [19:0] req_opcode;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_z;
  logic        rsp_c;
  logic        rsp_err;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic        alu_imm7;
  logic [7:0]  alu_result;
  logic        alu_z;
  logic        alu_c;

  // Arbiter side
  modport slave (
    input  req_valid, req_opcode, req_op1, req_op2, rsp_ready,
           alu_result, alu_z, alu_c,
    output req_ready, rsp_valid, rsp_data, rsp_z, rsp_c, rsp_err,
           alu_opcode, alu_op1, alu_op2, alu_imm7
  );

  // Requesters plus shared ALU side
  modport master (
    output req_valid, req_opcode, req_op1, req_op2, rsp_ready,
           alu_result, alu_z, alu_c,
    input  req_ready, rsp_valid, rsp_data, rsp_z, rsp_c, rsp_err,
           alu_opcode, alu_op1, alu_op2, alu_imm7
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU among four requesters.
// One operation in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module alu_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic          clk,
  input  logic          Reset,
  alu_arbiter_if.slave  bus,
  output logic [15:0]   ops_done
);

  localparam int unsigned PW  = $clog2(NREQ);
  localparam int unsigned OPW = 5;
  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 16;
  localparam logic [OPW-1:0] LAST_OP = 5'h08;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g_q, g_d;
  logic [OPW-1:0]  alu_opcode_q, alu_opcode_d;
  logic [DW-1:0]   alu_op1_q, alu_op1_d;
  logic [DW-1:0]   alu_op2_q, alu_op2_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_z_q, rsp_z_d;
  logic            rsp_c_q, rsp_c_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CW-1:0]   ops_done_q, ops_done_d;
  logic [NREQ-1:0] req_ready_c;

  logic [OPW-1:0]  opc_arr [NREQ];
  logic [DW-1:0]   op1_arr [NREQ];
  logic [DW-1:0]   op2_arr [NREQ];

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   scan_idx;

  // Split the flat payload buses into per-requester fields
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign opc_arr[i] = bus.req_opcode[i*OPW +: OPW];
    assign op1_arr[i] = bus.req_op1[i*DW +: DW];
    assign op2_arr[i] = bus.req_op2[i*DW +: DW];
  end

  // First requesting index at or after ptr, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = PW'(ptr_q + PW'(k));
      if (!gnt_found && bus.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Next-state, grant and response capture
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    g_d          = g_q;
    alu_opcode_d = alu_opcode_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_z_d      = rsp_z_q;
    rsp_c_d      = rsp_c_q;
    rsp_err_d    = rsp_err_q;
    ops_done_d   = ops_done_q;
    req_ready_c  = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready_c[gnt_idx] = 1'b1;
          g_d          = gnt_idx;
          ptr_d        = PW'(gnt_idx + PW'(1));
          alu_opcode_d = opc_arr[gnt_idx];
          alu_op1_d    = op1_arr[gnt_idx];
          alu_op2_d    = op2_arr[gnt_idx];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Illegal opcodes discard whatever the ALU produced
        if (alu_opcode_q > LAST_OP) begin
          rsp_data_d = '0;
          rsp_z_d    = 1'b1;
          rsp_c_d    = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = bus.alu_result;
          rsp_z_d    = bus.alu_z;
          rsp_c_d    = bus.alu_c;
          rsp_err_d  = 1'b0;
        end
        rsp_valid_d      = '0;
        rsp_valid_d[g_q] = 1'b1;
        state_d          = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[g_q]) begin
          rsp_valid_d = '0;
          if (ops_done_q != '1) begin
            ops_done_d = ops_done_q + CW'(1);
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      g_q          <= '0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_z_q      <= 1'b0;
      rsp_c_q      <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      g_q          <= g_d;
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_z_q      <= rsp_z_d;
      rsp_c_q      <= rsp_c_d;
      rsp_err_q    <= rsp_err_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // req_ready is the same-cycle accept and must read low while Reset is held
  assign bus.req_ready  = Reset ? '0 : req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_op1    = alu_op1_q;
  assign bus.alu_op2    = alu_op2_q;
  assign bus.alu_imm7   = 1'b0;
  assign ops_done       = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: shared-ALU model, transaction-level reference model,
// directed scenarios followed by randomized traffic with random resets.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] ops_done;

  alu_arbiter_if bus_if();

  alu_arbiter #(.NREQ(4)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .bus      (bus_if),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared ALU: result/flags registered one cycle after the drive values
  function automatic logic [8:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      5'h00:   return {1'b0, a} + {1'b0, b};
      5'h01:   return {1'b0, a} - {1'b0, b};
      5'h02:   return {1'b0, a & b};
      5'h03:   return {1'b0, a | b};
      5'h04:   return {1'b0, a ^ b};
      5'h05:   return {a, 1'b0};
      5'h06:   return {a[0], 1'b0, a[7:1]};
      5'h07:   return {1'b0, a} + 9'd1;
      5'h08:   return {8'h00, (a < b)};
      default: return {1'b1, a ^ b ^ 8'hA5};
    endcase
  endfunction

  logic [8:0] alu_next;
  assign alu_next = alu_fn(bus_if.alu_opcode, bus_if.alu_op1, bus_if.alu_op2);

  always @(posedge clk) begin
    bus_if.alu_result <= alu_next[7:0];
    bus_if.alu_c      <= alu_next[8];
    bus_if.alu_z      <= (alu_next[7:0] == 8'h00);
  end

  // Requester-side stimulus state
  logic [3:0] req_v;
  logic [4:0] req_opc [4];
  logic [7:0] req_a   [4];
  logic [7:0] req_b   [4];
  logic [3:0] rsp_rdy;
  logic       rst_drv;
  logic       rr_mode;
  logic       rand_mode;

  // Reference model: one operation outstanding, response due 3 cycles after accept
  logic        m_busy;
  int          m_age;
  int          m_g;
  int          m_ptr;
  logic [15:0] m_done;
  logic [7:0]  m_data;
  logic        m_z, m_c, m_err;
  logic [4:0]  m_aop;
  logic [7:0]  m_a1, m_a2;

  logic [3:0]  exp_rdy, exp_vld;
  logic [7:0]  exp_data;
  logic        exp_z, exp_c, exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    Reset = rst_drv;
    bus_if.req_valid = req_v;
    for (int i = 0; i < 4; i++) begin
      bus_if.req_opcode[i*5 +: 5] = req_opc[i];
      bus_if.req_op1[i*8 +: 8]    = req_a[i];
      bus_if.req_op2[i*8 +: 8]    = req_b[i];
    end
    bus_if.rsp_ready = rsp_rdy;
  endtask

  // Compare every DUT output with the model, then advance the model one cycle
  task automatic model_check();
    logic [8:0] r;
    int g;
    if (Reset) begin
      m_busy = 1'b0; m_age = 0; m_g = 0; m_ptr = 0; m_done = '0;
      m_data = '0; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
      m_aop = '0; m_a1 = '0; m_a2 = '0;
    end
    exp_rdy = '0;
    exp_vld = '0;
    g = -1;
    if (!Reset && !m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && req_v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    if (m_busy && m_age == 3) exp_vld[m_g] = 1'b1;
    exp_data = m_data; exp_z = m_z; exp_c = m_c; exp_err = m_err;

    chk("req_ready",  bus_if.req_ready,  exp_rdy);
    chk("rsp_valid",  bus_if.rsp_valid,  exp_vld);
    chk("rsp_data",   bus_if.rsp_data,   exp_data);
    chk("rsp_z",      bus_if.rsp_z,      exp_z);
    chk("rsp_c",      bus_if.rsp_c,      exp_c);
    chk("rsp_err",    bus_if.rsp_err,    exp_err);
    chk("alu_opcode", bus_if.alu_opcode, m_aop);
    chk("alu_op1",    bus_if.alu_op1,    m_a1);
    chk("alu_op2",    bus_if.alu_op2,    m_a2);
    chk("alu_imm7",   bus_if.alu_imm7,   1'b0);
    chk("ops_done",   ops_done,          m_done);

    if (!Reset) begin
      if (g >= 0) begin
        m_busy = 1'b1; m_age = 1; m_g = g;
        m_aop = req_opc[g]; m_a1 = req_a[g]; m_a2 = req_b[g];
        m_ptr = (g + 1) % 4;
        req_v[g] = rr_mode;
      end else if (m_busy && m_age == 1) begin
        m_age = 2;
      end else if (m_busy && m_age == 2) begin
        m_age = 3;
        if (m_aop > 5'h08) begin
          m_data = 8'h00; m_z = 1'b1; m_c = 1'b0; m_err = 1'b1;
        end else begin
          r = alu_fn(m_aop, m_a1, m_a2);
          m_data = r[7:0]; m_c = r[8]; m_z = (r[7:0] == 8'h00); m_err = 1'b0;
        end
      end else if (m_busy && m_age == 3 && rsp_rdy[m_g]) begin
        m_busy = 1'b0;
        if (m_done != 16'hFFFF) m_done = m_done + 16'd1;
      end
    end
  endtask

  task automatic gen_random();
    for (int i = 0; i < 4; i++) begin
      if (!req_v[i] && $urandom_range(0, 2) == 0) begin
        req_v[i]   = 1'b1;
        req_opc[i] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
        req_a[i]   = 8'($urandom);
        req_b[i]   = 8'($urandom);
      end
    end
    rsp_rdy = 4'($urandom);
    rst_drv = rst_drv ? 1'b0 : ($urandom_range(0, 149) == 0);
  endtask

  // One clock: drive just after the rising edge, check on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) gen_random();
    drive();
    @(negedge clk);
    model_check();
  endtask

  task automatic set_req(input int i, input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
    req_v[i] = 1'b1; req_opc[i] = o; req_a[i] = a; req_b[i] = b;
  endtask

  // Issue one request into an idle arbiter; returns in the first response cycle
  task automatic do_op(input int i, input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    set_req(i, o, a, b);
    step();
    chk("op_grant", bus_if.req_ready, oh);
    step(); step(); step();
    chk("op_rsp_valid", bus_if.rsp_valid, oh);
  endtask

  task automatic drain();
    rsp_rdy = 4'hF;
    req_v = '0;
    for (int n = 0; n < 10 && m_busy; n++) step();
    chk("drain_idle", m_busy, 1'b0);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 9;
    endcase
  endfunction

  initial begin
    int rr_got[$];
    req_v = '0; rsp_rdy = 4'hF; rst_drv = 1'b1; rr_mode = 1'b0; rand_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_opc[i] = '0; req_a[i] = '0; req_b[i] = '0;
    end
    drive();
    step(); step();
    chk("rst_ops_done", ops_done, 16'd0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 4'b0000);
    chk("rst_req_ready", bus_if.req_ready, 4'b0000);
    rst_drv = 1'b0;

    // Single add: F0 + 20 -> 10 with carry
    do_op(0, 5'h00, 8'hF0, 8'h20);
    chk("add_data", bus_if.rsp_data, 8'h10);
    chk("add_c", bus_if.rsp_c, 1'b1);
    chk("add_z", bus_if.rsp_z, 1'b0);
    chk("add_err", bus_if.rsp_err, 1'b0);
    chk("add_model_data", exp_data, 8'h10);
    chk("add_model_c", exp_c, 1'b1);

    // Compare: 3 < 7 -> 1, 7 < 3 -> 0
    do_op(3, 5'h08, 8'd3, 8'd7);
    chk("cmp_lt_data", bus_if.rsp_data, 8'h01);
    chk("cmp_lt_z", bus_if.rsp_z, 1'b0);
    chk("cmp_model_data", exp_data, 8'h01);
    do_op(3, 5'h08, 8'd7, 8'd3);
    chk("cmp_ge_data", bus_if.rsp_data, 8'h00);
    chk("cmp_ge_z", bus_if.rsp_z, 1'b1);

    // Illegal opcode from requester 2
    do_op(2, 5'h1F, 8'h55, 8'h66);
    chk("ill_data", bus_if.rsp_data, 8'h00);
    chk("ill_z", bus_if.rsp_z, 1'b1);
    chk("ill_c", bus_if.rsp_c, 1'b0);
    chk("ill_err", bus_if.rsp_err, 1'b1);
    chk("ill_model_err", exp_err, 1'b1);
    chk("ill_done_before", ops_done, 16'd3);

    // Backpressure on requester 1; other rsp_ready bits high and a new request waiting
    rsp_rdy = 4'b1101;
    do_op(1, 5'h01, 8'h10, 8'h30);
    chk("bp_data0", bus_if.rsp_data, 8'hE0);
    chk("bp_c0", bus_if.rsp_c, 1'b1);
    set_req(0, 5'h04, 8'hFF, 8'h0F);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("bp_valid", bus_if.rsp_valid, 4'b0010);
      chk("bp_data", bus_if.rsp_data, 8'hE0);
      chk("bp_done", ops_done, 16'd4);
      chk("bp_no_grant", bus_if.req_ready, 4'b0000);
    end
    rsp_rdy = 4'hF;
    step();
    chk("bp_last_valid", bus_if.rsp_valid, 4'b0010);
    step();
    chk("bp_done_after", ops_done, 16'd5);
    chk("bp_waiter_grant", bus_if.req_ready, 4'b0001);
    step(); step(); step();
    chk("bp_waiter_rsp", bus_if.rsp_valid, 4'b0001);
    chk("bp_waiter_data", bus_if.rsp_data, 8'hF0);
    drain();

    // Round-robin with all four held from reset
    rst_drv = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i), 8'(i + 1), 8'h11);
    step();
    rst_drv = 1'b0;
    rr_mode = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus_if.req_ready != 4'b0000) rr_got.push_back(oh2i(bus_if.req_ready));
    end
    chk("rr_count", rr_got.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", (rr_got.size() > k) ? rr_got[k] : -1, k % 4);
    end
    rr_mode = 1'b0;
    drain();

    // Reset during WAIT discards the operation; held requesters restart from ptr 0
    set_req(2, 5'h04, 8'h3C, 8'h0F);
    step();
    chk("rw_grant", bus_if.req_ready, 4'b0100);
    set_req(1, 5'h00, 8'h01, 8'h02);
    set_req(3, 5'h00, 8'h05, 8'h06);
    step();
    rst_drv = 1'b1;
    step();
    chk("rw_rst_valid", bus_if.rsp_valid, 4'b0000);
    chk("rw_rst_opcode", bus_if.alu_opcode, 5'h00);
    chk("rw_rst_op1", bus_if.alu_op1, 8'h00);
    chk("rw_rst_done", ops_done, 16'd0);
    chk("rw_rst_ready", bus_if.req_ready, 4'b0000);
    rst_drv = 1'b0;
    step();
    chk("rw_regrant", bus_if.req_ready, 4'b0010);
    step(); step(); step();
    chk("rw_rsp", bus_if.rsp_valid, 4'b0010);
    chk("rw_data", bus_if.rsp_data, 8'h03);
    drain();

    // Randomized traffic with occasional resets
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) step();
    rand_mode = 1'b0;
    rst_drv = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
